// File: rtl/master_slave_ff_pkg.sv
// Shared constants for the master-slave flip-flop cell.
`timescale 1ns/1ps
package master_slave_ff_pkg;

  localparam int unsigned MSFF_DEFAULT_WIDTH = 1;

endpackage

// File: rtl/master_slave_ff_if.sv
// Data bundle around a master_slave_ff instance: the driver owns d, the cell owns q.
`timescale 1ns/1ps
interface master_slave_ff_if
  import master_slave_ff_pkg::*;
#(
  parameter int unsigned WIDTH = MSFF_DEFAULT_WIDTH
);

  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;

  modport master (output d, input q);
  modport slave  (input d, output q);

endinterface

// File: rtl/master_slave_ff_latch.sv
// Level-sensitive D latch with asynchronous active-low clear; one half of the flip-flop.
`timescale 1ns/1ps
module ms_d_latch #(
  parameter int unsigned     WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             en,
  input  logic             rstn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // NOTE: always_latch makes the storage intent explicit; the missing else-branch
  // (en=0) is the intended hold state, not an accident.
  always_latch begin
    if (!rstn) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/master_slave_ff.sv
// Rising-edge D flip-flop built from two latches: master open while clk=0, slave while clk=1.
`timescale 1ns/1ps
module master_slave_ff
  import master_slave_ff_pkg::*;
#(
  parameter int unsigned      WIDTH   = MSFF_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] master_q;

  // Master closes on the rising edge exactly as the slave opens, so q only
  // ever sees the value d held at that edge.
  ms_d_latch #(
    .WIDTH   (WIDTH),
    .RST_VAL (RST_VAL)
  ) u_master (
    .en   (~clk),
    .rstn (rstn),
    .d    (d),
    .q    (master_q)
  );

  ms_d_latch #(
    .WIDTH   (WIDTH),
    .RST_VAL (RST_VAL)
  ) u_slave (
    .en   (clk),
    .rstn (rstn),
    .d    (master_q),
    .q    (q)
  );

endmodule

// File: tb/tb_master_slave_ff.sv
// Directed bench for master_slave_ff: 1-bit instance plus an 8-bit instance with RST_VAL=A5.
`timescale 1ns/1ps
module tb_master_slave_ff;

  logic clk;
  logic rstn;
  logic rstn8;

  int errors = 0;
  int checks = 0;

  master_slave_ff_if #(.WIDTH(1)) bus1 ();
  master_slave_ff_if #(.WIDTH(8)) bus8 ();

  master_slave_ff #(
    .WIDTH   (1),
    .RST_VAL (1'b0)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .d    (bus1.d),
    .q    (bus1.q)
  );

  master_slave_ff #(
    .WIDTH   (8),
    .RST_VAL (8'hA5)
  ) dut8 (
    .clk  (clk),
    .rstn (rstn8),
    .d    (bus8.d),
    .q    (bus8.q)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic at(input int t);
    if (t > $time) #(t - $time);
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    // Step 1: reset held, including across the 5 ns rising edge.
    rstn   = 1'b0;
    rstn8  = 1'b0;
    bus1.d = 1'b0;
    bus8.d = 8'h00;
    at(1);  check("rst_q_t1", {7'd0, bus1.q}, 8'h00);
            check("rst8_q_t1", bus8.q, 8'hA5);
    bus1.d = 1'b1;
    at(4);  bus1.d = 1'b1;
    at(6);  check("rst_q_across_edge", {7'd0, bus1.q}, 8'h00);
    bus1.d = 1'b0;

    // Step 2: release reset at 10 ns with d=0.
    at(10); rstn = 1'b1;
    at(11); check("rel_q_t11", {7'd0, bus1.q}, 8'h00);
    at(16); check("edge15_q", {7'd0, bus1.q}, 8'h00);

    // Step 3: d on falling edges, q updates on rising edges only.
    at(20); bus1.d = 1'b1;
    at(21); check("fall20_q_hold", {7'd0, bus1.q}, 8'h00);
            check("fall20_master", {7'd0, dut.master_q}, 8'h01);
    at(26); check("edge25_q", {7'd0, bus1.q}, 8'h01);
    at(30); bus1.d = 1'b0;
    at(31); check("fall30_q_hold", {7'd0, bus1.q}, 8'h01);
    at(36); check("edge35_q", {7'd0, bus1.q}, 8'h00);
    at(40); bus1.d = 1'b1;
    at(41); check("fall40_q_hold", {7'd0, bus1.q}, 8'h00);
    at(46); check("edge45_q", {7'd0, bus1.q}, 8'h01);

    // Step 4a: d toggles during clk=1 must not reach q.
    bus1.d = 1'b0;
    at(47); check("hi_toggle0_q", {7'd0, bus1.q}, 8'h01);
    bus1.d = 1'b1;
    at(48); bus1.d = 1'b0;
    at(49); check("hi_toggle1_q", {7'd0, bus1.q}, 8'h01);
            check("hi_master_hold", {7'd0, dut.master_q}, 8'h01);

    // Step 4b: d toggles during clk=0 move master_q only.
    at(51); bus1.d = 1'b1;
    at(52); check("lo_master_1", {7'd0, dut.master_q}, 8'h01);
    bus1.d = 1'b0;
    at(53); check("lo_master_0", {7'd0, dut.master_q}, 8'h00);
            check("lo_q_hold", {7'd0, bus1.q}, 8'h01);
    bus1.d = 1'b1;
    at(56); check("edge55_q", {7'd0, bus1.q}, 8'h01);

    // Step 5: 2 ns reset pulse during clk=1 with q=1.
    bus1.d = 1'b0;
    rstn = 1'b0;
    at(57); check("pulse_q_now", {7'd0, bus1.q}, 8'h00);
    at(58); rstn = 1'b1;
    at(59); check("pulse_rel_hi_q", {7'd0, bus1.q}, 8'h00);
    at(60); bus1.d = 1'b1;
    at(61); check("pulse_lo_q", {7'd0, bus1.q}, 8'h00);
            check("pulse_lo_master", {7'd0, dut.master_q}, 8'h01);
    at(66); check("edge65_q", {7'd0, bus1.q}, 8'h01);

    // Step 6: 8-bit instance, consecutive rising edges.
    at(70); rstn8 = 1'b1; bus8.d = 8'h3C;
    at(71); check("w8_rel_q", bus8.q, 8'hA5);
    at(76); check("w8_edge75", bus8.q, 8'h3C);
    at(80); bus8.d = 8'h5A;
    at(81); check("w8_fall80_hold", bus8.q, 8'h3C);
    at(86); check("w8_edge85", bus8.q, 8'h5A);
    at(90); bus8.d = 8'hFF;
    at(96); check("w8_edge95", bus8.q, 8'hFF);

    // Reset asserted and released while clk=0 on the 8-bit instance.
    at(101); rstn8 = 1'b0;
    at(102); check("w8_lo_rst_q", bus8.q, 8'hA5);
    at(103); rstn8 = 1'b1;
    at(104); check("w8_lo_rel_q", bus8.q, 8'hA5);
             check("w8_lo_rel_master", dut8.master_q, 8'hFF);
    at(106); check("w8_edge105", bus8.q, 8'hFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
